// File: rtl/store_buffer_if.sv
// Access-width type and the commit/memory/load bundle of the store buffer.
// The buffer takes the slave view; the commit stage and memory take the master view.
package store_buffer_pkg;
    typedef enum logic [1:0] {
        LDST_BYTE = 2'd0,
        LDST_HALF = 2'd1,
        LDST_WORD = 2'd2
    } ldst_mode;
endpackage

interface store_buffer_if;
    import store_buffer_pkg::*;

    logic        store_enable;
    ldst_mode    store_mode;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        sb_full;
    logic        sb_empty;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] load_addr;
    logic        fwd_hazard;

    modport master (
        output store_enable, store_mode, store_addr, store_data, mem_ack, load_addr,
        input  sb_full, sb_empty, mem_req, mem_addr, mem_wdata, mem_wstrb, fwd_hazard
    );

    modport slave (
        input  store_enable, store_mode, store_addr, store_data, mem_ack, load_addr,
        output sb_full, sb_empty, mem_req, mem_addr, mem_wdata, mem_wstrb, fwd_hazard
    );
endinterface

// File: rtl/store_buffer.sv
// Circular FIFO of committed stores drained to data memory in program order,
// with a load-address hazard flag over every pending entry.
module store_buffer_chk (
    input logic clk,
    input logic rst,
    input logic store_enable,
    input logic sb_full
);
    // Commit must never present a store while the buffer reports full.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(store_enable && sb_full))
                else $warning("store_buffer: store presented while full, dropped");
        end
    end
endmodule

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int SB_DEPTH     = 4,
    parameter int SB_DEPTH_LOG = 2
) (
    input logic          clk,
    input logic          rst,
    store_buffer_if.slave sb
);
    typedef struct packed {
        logic [29:0] word;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    localparam logic [SB_DEPTH_LOG:0]   FULL_COUNT = (SB_DEPTH_LOG + 1)'(SB_DEPTH);
    localparam logic [SB_DEPTH_LOG:0]   ONE_COUNT  = (SB_DEPTH_LOG + 1)'(1);
    localparam logic [SB_DEPTH_LOG-1:0] ONE_PTR    = SB_DEPTH_LOG'(1);

    // Lane placement is resolved at enqueue so the drain path is a plain mux.
    function automatic entry_t encode_store(input ldst_mode mode, input logic [31:0] addr,
                                            input logic [31:0] data);
        entry_t e;
        e.word = addr[31:2];
        case (mode)
            LDST_BYTE: begin
                e.wstrb = 4'b0001 << addr[1:0];
                e.wdata = {4{data[7:0]}};
            end
            LDST_HALF: begin
                e.wstrb = addr[1] ? 4'b1100 : 4'b0011;
                e.wdata = {2{data[15:0]}};
            end
            default: begin
                e.wstrb = 4'b1111;
                e.wdata = data;
            end
        endcase
        return e;
    endfunction

    entry_t                  entry_r [SB_DEPTH];
    logic [SB_DEPTH-1:0]     valid_r;
    logic [SB_DEPTH_LOG-1:0] head_r;
    logic [SB_DEPTH_LOG-1:0] tail_r;
    logic [SB_DEPTH_LOG:0]   count_r;
    logic [SB_DEPTH_LOG:0]   count_next_s;
    logic                    full_r;
    logic                    empty_r;
    logic                    enq_s;
    logic                    pop_s;
    logic                    hazard_s;
    entry_t                  head_s;

    // Full blocks enqueue even when a pop frees a slot in the same cycle.
    assign enq_s = sb.store_enable && !full_r;
    assign pop_s = !empty_r && sb.mem_ack;

    // Occupancy after this cycle's enqueue/pop.
    always_comb begin
        count_next_s = count_r;
        case ({enq_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_COUNT;
            2'b01:   count_next_s = count_r - ONE_COUNT;
            default: count_next_s = count_r;
        endcase
    end

    // Entry storage, pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (enq_s) begin
                entry_r[tail_r] <= encode_store(sb.store_mode, sb.store_addr, sb.store_data);
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + ONE_PTR;
            end
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + ONE_PTR;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_COUNT);
            empty_r <= (count_next_s == '0);
        end
    end

    // Drain port and hazard flag; the head still counts while it is being popped.
    always_comb begin
        head_s   = entry_r[head_r];
        hazard_s = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid_r[i] && ({entry_r[i].word, 2'b00} == (sb.load_addr & 32'hFFFF_FFFC))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        if (empty_r) begin
            sb.mem_addr  = 32'h0000_0000;
            sb.mem_wdata = 32'h0000_0000;
            sb.mem_wstrb = 4'b0000;
        end else begin
            sb.mem_addr  = {head_s.word, 2'b00};
            sb.mem_wdata = head_s.wdata;
            sb.mem_wstrb = head_s.wstrb;
        end
    end

    assign sb.mem_req    = !empty_r;
    assign sb.sb_full    = full_r;
    assign sb.sb_empty   = empty_r;
    assign sb.fwd_hazard = hazard_s;

    store_buffer_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .store_enable (sb.store_enable),
        .sb_full      (full_r)
    );
endmodule
